// File: rtl/pipe_exe_md_stage.sv
// EX stage: 1-cycle ALU/jal/mfhi/mflo result; multu/divu run iteratively with HI/LO written 33 cycles after issue.
// Backpressure: stall is held for the whole mul/div, and gated control bits make EXE/MEM capture bubbles meanwhile.
module pipe_exe_md_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [3:0]  ealuc,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic        ejal,
  input  logic [2:0]  emdop,
  input  logic [4:0]  ern0,
  input  logic [31:0] epc4,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  output logic [31:0] ealu,
  output logic [31:0] eb_o,
  output logic [4:0]  ern,
  output logic        ewreg_o,
  output logic        em2reg_o,
  output logic        ewmem_o,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_MFHI  = 3'b011;
  localparam logic [2:0] MD_MFLO  = 3'b100;

  state_t      state, state_nx;
  logic [4:0]  count;
  logic        md_div;
  logic [31:0] md_opnd;
  logic [31:0] acc_hi, acc_lo;
  logic [31:0] hi, lo;

  logic [31:0] opa, opb, alu_res;
  logic        md_issue;

  assign opa      = eshift ? {27'b0, eimm[10:6]} : ea;
  assign opb      = ealuimm ? eimm : eb;
  assign md_issue = (emdop == MD_MULTU) || (emdop == MD_DIVU);

  always_comb begin
    alu_res = 32'b0;
    case (ealuc[2:0])
      3'b000: alu_res = opa + opb;
      3'b100: alu_res = opa - opb;
      3'b001: alu_res = opa & opb;
      3'b101: alu_res = opa | opb;
      3'b010: alu_res = opa ^ opb;
      3'b110: alu_res = {opb[15:0], 16'b0};
      3'b011: alu_res = opb << opa[4:0];
      3'b111: alu_res = ealuc[3] ? 32'($signed(opb) >>> opa[4:0]) : (opb >> opa[4:0]);
      default: alu_res = 32'b0;
    endcase
  end

  // One iteration step. Multiply: {acc_hi,acc_lo} holds partial product and
  // remaining multiplier bits. Divide: acc_hi is the partial remainder and
  // acc_lo shifts dividend bits out while quotient bits shift in.
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [31:0] acc_hi_nx, acc_lo_nx;

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_opnd} : 33'b0);
    div_sh  = {acc_hi, acc_lo[31]};
    div_ge  = div_sh >= {1'b0, md_opnd};
    div_rem = div_sh[31:0] - md_opnd;
    if (md_div) begin
      acc_hi_nx = div_ge ? div_rem : div_sh[31:0];
      acc_lo_nx = {acc_lo[30:0], div_ge};
    end else begin
      acc_hi_nx = mul_sum[32:1];
      acc_lo_nx = {mul_sum[0], acc_lo[31:1]};
    end
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (md_issue) begin
          state_nx = BUSY;
          stall    = resetn;
        end
      end
      BUSY: begin
        stall = resetn;
        if (count == 5'd31) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      count   <= 5'd0;
      md_div  <= 1'b0;
      md_opnd <= 32'b0;
      acc_hi  <= 32'b0;
      acc_lo  <= 32'b0;
      hi      <= 32'b0;
      lo      <= 32'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (md_issue) begin
            md_div  <= (emdop == MD_DIVU);
            md_opnd <= (emdop == MD_DIVU) ? opb : opa;
            acc_lo  <= (emdop == MD_DIVU) ? opa : opb;
            acc_hi  <= 32'b0;
            count   <= 5'd0;
          end
        end
        BUSY: begin
          acc_hi <= acc_hi_nx;
          acc_lo <= acc_lo_nx;
          count  <= count + 5'd1;
        end
        DONE: begin
          // Product and quotient/remainder land in the same halves.
          hi <= acc_hi;
          lo <= acc_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (ejal)                   ealu = epc4 + 32'd4;
    else if (emdop == MD_MFHI)  ealu = hi;
    else if (emdop == MD_MFLO)  ealu = lo;
    else                        ealu = alu_res;
  end

  assign ern      = ejal ? 5'd31 : ern0;
  assign eb_o     = eb;
  assign ewreg_o  = ewreg  & ~stall;
  assign em2reg_o = em2reg & ~stall;
  assign ewmem_o  = ewmem  & ~stall;

endmodule

// File: tb/tb_pipe_exe_md_stage.sv
// Self-checking bench for pipe_exe_md_stage: directed cases plus randomized
// ALU and mul/div traffic against an arithmetic reference model.
module tb_pipe_exe_md_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ewreg, em2reg, ewmem;
  logic [3:0]  ealuc;
  logic        ealuimm, eshift, ejal;
  logic [2:0]  emdop;
  logic [4:0]  ern0;
  logic [31:0] epc4, ea, eb, eimm;
  logic [31:0] ealu, eb_o;
  logic [4:0]  ern;
  logic        ewreg_o, em2reg_o, ewmem_o, stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  pipe_exe_md_stage dut (
    .clk(clk), .resetn(resetn),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal),
    .emdop(emdop), .ern0(ern0), .epc4(epc4), .ea(ea), .eb(eb), .eimm(eimm),
    .ealu(ealu), .eb_o(eb_o), .ern(ern),
    .ewreg_o(ewreg_o), .em2reg_o(em2reg_o), .ewmem_o(ewmem_o), .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ewreg = 0; em2reg = 0; ewmem = 0; ealuc = 0; ealuimm = 0; eshift = 0;
    ejal = 0; emdop = 0; ern0 = 0; epc4 = 0; ea = 0; eb = 0; eimm = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (c[2:0])
      3'd0: r = a + b;
      3'd4: r = a - b;
      3'd1: r = a & b;
      3'd5: r = a | b;
      3'd2: r = a ^ b;
      3'd6: r = b * 32'h10000;
      3'd3: r = b << a[4:0];
      default: r = c[3] ? 32'($signed(b) >>> a[4:0]) : (b >> a[4:0]);
    endcase
    return r;
  endfunction

  task automatic alu_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic aluimm,
                        input logic shift, input logic [4:0] rn, input logic [31:0] exp);
    idle_inputs();
    ealuc = c; ea = a; eb = b; eimm = imm; ealuimm = aluimm; eshift = shift;
    ern0 = rn; ewreg = 1; em2reg = rn[0]; ewmem = rn[1];
    @(negedge clk);
    check({tag, ".ealu"}, ealu, exp);
    check({tag, ".ern"}, 32'(ern), 32'(rn));
    check({tag, ".ewreg_o"}, 32'(ewreg_o), 32'd1);
    check({tag, ".ctl"}, {30'b0, ewmem_o, em2reg_o}, {30'b0, rn[1], rn[0]});
    check({tag, ".eb_o"}, eb_o, b);
    check({tag, ".stall"}, 32'(stall), 32'd0);
    next_cycle();
  endtask

  task automatic rand_alu(input string tag);
    logic [3:0]  c;
    logic [31:0] a, b, imm, opa, opb;
    logic        ai, sh;
    c = 4'($urandom_range(0, 15));
    if (c == 4'b1011) c = 4'b0011;
    a = $urandom; b = $urandom; imm = $urandom;
    ai = 1'($urandom); sh = 1'($urandom);
    opa = sh ? 32'(imm[10:6]) : a;
    opb = ai ? imm : b;
    alu_op(tag, c, a, b, imm, ai, sh, 5'($urandom), ref_alu(c, opa, opb));
  endtask

  task automatic md_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int n_stall = 0;
    int n_pass = 0;
    logic [63:0] prod;
    idle_inputs();
    emdop = op; ea = a; eb = b; ewreg = 1; ern0 = 5'd9;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (ewreg_o) n_pass++;
      if (!stall) break;
      n_stall++;
      next_cycle();
    end
    check({tag, ".stall_cycles"}, 32'(n_stall), 32'd33);
    check({tag, ".passed_once"}, 32'(n_pass), 32'd1);
    if (op == 3'b001) begin
      prod = 64'(a) * 64'(b);
      m_hi = prod[63:32];
      m_lo = prod[31:0];
    end else if (b == 0) begin
      m_lo = 32'hFFFF_FFFF;
      m_hi = a;
    end else begin
      m_lo = a / b;
      m_hi = a % b;
    end
    next_cycle();
  endtask

  task automatic mf(input string tag, input logic [2:0] op, input logic [31:0] exp);
    idle_inputs();
    emdop = op; ewreg = 1; ern0 = 5'd3;
    @(negedge clk);
    check({tag, ".ealu"}, ealu, exp);
    check({tag, ".stall"}, 32'(stall), 32'd0);
    check({tag, ".ewreg_o"}, 32'(ewreg_o), 32'd1);
    next_cycle();
  endtask

  task automatic jal_op(input string tag, input logic [31:0] pc4);
    idle_inputs();
    ejal = 1; epc4 = pc4; ewreg = 1; ern0 = 5'd5; ea = $urandom; eb = $urandom;
    @(negedge clk);
    check({tag, ".ealu"}, ealu, pc4 + 32'd4);
    check({tag, ".ern"}, 32'(ern), 32'd31);
    check({tag, ".ewreg_o"}, 32'(ewreg_o), 32'd1);
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    emdop = 3'b011;
    resetn = 0;
    m_hi = 0; m_lo = 0;
    #12;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.hi", ealu, 32'd0);
    @(negedge clk);
    resetn = 1;
    next_cycle();
    mf("rst_mflo", 3'b100, 32'd0);

    md_op("mul_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mf("mul_max_hi", 3'b011, 32'hFFFF_FFFE);
    mf("mul_max_lo", 3'b100, 32'h0000_0001);

    md_op("div_100_7", 3'b010, 32'd100, 32'd7);
    mf("div_lo", 3'b100, 32'd14);
    mf("div_hi", 3'b011, 32'd2);
    md_op("div_5_0", 3'b010, 32'd5, 32'd0);
    mf("div0_lo", 3'b100, 32'hFFFF_FFFF);
    mf("div0_hi", 3'b011, 32'd5);

    alu_op("sub", 4'b0100, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 5'd1, 32'hFFFF_FFFE);
    alu_op("sra", 4'b1111, 32'h1234, 32'h8000_0000, 32'h100, 1'b0, 1'b1, 5'd2, 32'hF800_0000);
    alu_op("lui", 4'b0110, 32'd0, 32'd0, 32'h1234, 1'b1, 1'b0, 5'd3, 32'h1234_0000);
    alu_op("sll", 4'b0011, 32'd0, 32'd1, 32'hC0, 1'b0, 1'b1, 5'd4, 32'd8);
    jal_op("jal", 32'h0040_0004);

    md_op("b2b_mul", 3'b001, $urandom, $urandom);
    md_op("b2b_div", 3'b010, $urandom, $urandom_range(1, 1000));
    mf("b2b_hi", 3'b011, m_hi);
    mf("b2b_lo", 3'b100, m_lo);

    for (int i = 0; i < 30; i++) rand_alu("rand_alu");
    for (int i = 0; i < 6; i++) begin
      md_op("rand_md", 3'($urandom_range(1, 2)), $urandom,
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
      mf("rand_hi", 3'b011, m_hi);
      mf("rand_lo", 3'b100, m_lo);
    end
    jal_op("rand_jal", $urandom);

    // Kill a multiply at count=10: issue cycle plus ten BUSY cycles.
    idle_inputs();
    emdop = 3'b001; ea = 32'd123; eb = 32'd456;
    repeat (11) next_cycle();
    check("midrst.stall_before", 32'(stall), 32'd1);
    #2;
    resetn = 0;
    #1;
    check("midrst.stall_async", 32'(stall), 32'd0);
    idle_inputs();
    emdop = 3'b011;
    m_hi = 0; m_lo = 0;
    @(negedge clk);
    resetn = 1;
    next_cycle();
    mf("midrst_hi", 3'b011, 32'd0);
    alu_op("midrst_add", 4'b0000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 5'd7, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
